// File: rtl/fpm_issue_seq.sv
// fpm_issue_seq: buffers operand pairs in a small FIFO and issues them one at a
// time to the shift-add FP multiplier, returning each product with a sequence tag.
// A watchdog forces an error result if the multiplier never answers.
module fpm_issue_seq #(
    parameter int P       = 8,
    parameter int Q       = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             op_valid_in,
    output logic             op_ready_out,
    input  logic [P+Q-1:0]   op_x_in,
    input  logic [P+Q-1:0]   op_y_in,
    input  logic [1:0]       op_round_in,
    output logic             mul_start_out,
    output logic [P+Q-1:0]   mul_x_out,
    output logic [P+Q-1:0]   mul_y_out,
    output logic [1:0]       mul_round_out,
    input  logic             mul_ready_in,
    input  logic             mul_valid_in,
    input  logic [P+Q-1:0]   mul_p_in,
    input  logic [3:0]       mul_oor_in,
    output logic             res_valid_out,
    input  logic             res_ready_in,
    output logic [P+Q-1:0]   res_p_out,
    output logic [3:0]       res_oor_out,
    output logic [1:0]       res_tag_out,
    output logic             res_err_out
);
    localparam int W   = P + Q;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNW = AW + 1;
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam int EW  = 2 * W + 2;
    localparam logic [CNW-1:0] L_DEPTH   = CNW'(DEPTH);
    localparam logic [WDW-1:0] L_TIMEOUT = WDW'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

    // Product returned on a watchdog timeout: positive, all-ones exponent,
    // fraction LSB set (a quiet-NaN-like marker; 0x7F81 for P=Q=8).
    function automatic logic [W-1:0] f_err_product();
        logic [W-1:0] v;
        v          = '0;
        v[W-2 -: P] = '1;
        v[0]       = 1'b1;
        return v;
    endfunction

    // Watchdog increment that sticks at TIMEOUT instead of wrapping.
    function automatic logic [WDW-1:0] f_sat_inc(input logic [WDW-1:0] c);
        return (c >= L_TIMEOUT) ? c : c + WDW'(1);
    endfunction

    state_t           r_state;
    state_t           w_next;
    logic [EW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNW-1:0]   r_count;
    logic [WDW-1:0]   r_wdog;
    logic [WDW-1:0]   w_wdog_inc;
    logic [1:0]       r_tag;
    logic             w_push;
    logic             w_issue;
    logic             w_capture;
    logic             w_timeout;
    logic [EW-1:0]    w_head;

    assign op_ready_out  = (r_count != L_DEPTH);
    assign w_push        = op_valid_in && op_ready_out;
    assign w_wdog_inc    = f_sat_inc(r_wdog);
    assign w_head        = r_mem[r_rd_ptr];
    assign mul_start_out = (r_state == S_ISSUE);
    assign res_valid_out = (r_state == S_HOLD);

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode; the first WAIT cycle (watchdog still zero) ignores a
    // valid that may be left over from the previous operation.
    always_comb begin
        w_next    = r_state;
        w_issue   = 1'b0;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((r_count != '0) && mul_ready_in) begin
                    w_issue = 1'b1;
                    w_next  = S_ISSUE;
                end
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (r_wdog != '0) begin
                    if (mul_valid_in) begin
                        w_capture = 1'b1;
                        w_next    = S_HOLD;
                    end else if (w_wdog_inc == L_TIMEOUT) begin
                        w_timeout = 1'b1;
                        w_next    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (res_ready_in) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand storage; contents are don't-care until written.
    always_ff @(posedge clk_in) begin
        if (w_push) r_mem[r_wr_ptr] <= {op_round_in, op_y_in, op_x_in};
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)  r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_issue) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + CNW'(1);
                2'b01:   r_count <= r_count - CNW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Operands to the multiplier, held from issue until the next issue.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mul_x_out     <= '0;
            mul_y_out     <= '0;
            mul_round_out <= '0;
        end else if (w_issue) begin
            mul_x_out     <= w_head[W-1:0];
            mul_y_out     <= w_head[2*W-1:W];
            mul_round_out <= w_head[EW-1:2*W];
        end
    end

    // Watchdog: cleared on issue, counts every WAIT cycle, saturates at TIMEOUT.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)                    r_wdog <= '0;
        else if (r_state == S_ISSUE)   r_wdog <= '0;
        else if (r_state == S_WAIT)    r_wdog <= w_wdog_inc;
    end

    // Result capture from the multiplier or forced by the watchdog; tag advances on both.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            res_p_out   <= '0;
            res_oor_out <= '0;
            res_tag_out <= '0;
            res_err_out <= 1'b0;
            r_tag       <= '0;
        end else if (w_capture) begin
            res_p_out   <= mul_p_in;
            res_oor_out <= mul_oor_in;
            res_tag_out <= r_tag;
            res_err_out <= 1'b0;
            r_tag       <= r_tag + 2'd1;
        end else if (w_timeout) begin
            res_p_out   <= f_err_product();
            res_oor_out <= 4'b0010;
            res_tag_out <= r_tag;
            res_err_out <= 1'b1;
            r_tag       <= r_tag + 2'd1;
        end
    end
endmodule

// File: tb/tb_fpm_issue_seq.sv
// tb_fpm_issue_seq: scoreboard bench for fpm_issue_seq with a behavioural
// multiplier stand-in and randomized operands, latencies and result stalls.
module tb_fpm_issue_seq;
    localparam int P = 8, Q = 8, DEPTH = 4, TIMEOUT = 32, W = 16;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          op_valid_in, op_ready_out;
    logic [W-1:0]  op_x_in, op_y_in;
    logic [1:0]    op_round_in;
    logic          mul_start_out;
    logic [W-1:0]  mul_x_out, mul_y_out;
    logic [1:0]    mul_round_out;
    logic          mul_ready_in, mul_valid_in;
    logic [W-1:0]  mul_p_in;
    logic [3:0]    mul_oor_in;
    logic          res_valid_out, res_ready_in;
    logic [W-1:0]  res_p_out;
    logic [3:0]    res_oor_out;
    logic [1:0]    res_tag_out;
    logic          res_err_out;

    fpm_issue_seq #(.P(P), .Q(Q), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .op_valid_in(op_valid_in), .op_ready_out(op_ready_out),
        .op_x_in(op_x_in), .op_y_in(op_y_in), .op_round_in(op_round_in),
        .mul_start_out(mul_start_out), .mul_x_out(mul_x_out), .mul_y_out(mul_y_out),
        .mul_round_out(mul_round_out), .mul_ready_in(mul_ready_in),
        .mul_valid_in(mul_valid_in), .mul_p_in(mul_p_in), .mul_oor_in(mul_oor_in),
        .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
        .res_p_out(res_p_out), .res_oor_out(res_oor_out),
        .res_tag_out(res_tag_out), .res_err_out(res_err_out)
    );

    initial forever #5 clk_in = ~clk_in;

    typedef struct {
        logic [W-1:0] p;
        logic [3:0]   oor;
        logic [1:0]   tag;
        logic         err;
        int           lat;
        int           exp_cyc;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         n_starts = 0;
    int         n_results = 0;
    int         cur_lat = 12;
    int         stall_cfg = 0;
    bit         rand_stall = 0;
    bit         stale_mode = 0;
    bit         rand_on = 0;
    bit         hold_active = 0;
    logic [1:0] ref_tag = 2'd0;
    time        t_start = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    endtask

    // Stand-in multiplier function: the 1.5 x 2.0 pair gives 3.0; anything else a scrambled mix.
    function automatic logic [19:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [1:0] r);
        logic [W-1:0] p;
        if (x == 16'h3FC0 && y == 16'h4000 && r == 2'd0) return {4'h0, 16'h4040};
        p = (x ^ {y[7:0], y[15:8]}) + {14'd0, r};
        return {x[3:0] ^ y[7:4], p};
    endfunction

    // Expected outcome of one accepted pair, given the multiplier latency it will see.
    task automatic sb_push(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] r);
        exp_t        e;
        logic [19:0] m;
        e.lat = cur_lat;
        if (cur_lat == 0 || cur_lat > TIMEOUT) begin
            e.p = 16'h7F81; e.oor = 4'b0010; e.err = 1'b1; e.exp_cyc = 1 + TIMEOUT;
        end else begin
            m = ref_mul(x, y, r);
            e.p = m[15:0]; e.oor = m[19:16]; e.err = 1'b0;
            e.exp_cyc = 1 + ((cur_lat < 2) ? 2 : cur_lat);
        end
        e.tag = ref_tag;
        ref_tag = ref_tag + 2'd1;
        sb_q.push_back(e);
    endtask

    task automatic push_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] r);
        int n;
        n = 0;
        op_x_in = x; op_y_in = y; op_round_in = r; op_valid_in = 1'b1;
        while (!op_ready_out && n < 3000) begin
            @(negedge clk_in);
            n++;
        end
        chk("push_ready", op_ready_out, 1);
        if (op_ready_out) sb_push(x, y, r);
        @(negedge clk_in);
        op_valid_in = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || hold_active || res_valid_out) && n < 5000) begin
            @(negedge clk_in);
            n++;
        end
        chk({"drain_", nm}, (sb_q.size() == 0 && !hold_active), 1);
    endtask

    // Multiplier stand-in: valid (sticky) appears 'lat' cycles after the start pulse.
    initial begin : mock_mul
        int          cd;
        logic        prev_start;
        logic [19:0] m;
        cd = 0; prev_start = 1'b0;
        mul_valid_in = 1'b0; mul_p_in = '0; mul_oor_in = '0;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                cd = 0; prev_start = 1'b0; mul_valid_in = 1'b0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        m = ref_mul(mul_x_out, mul_y_out, mul_round_out);
                        mul_p_in = m[15:0]; mul_oor_in = m[19:16]; mul_valid_in = 1'b1;
                    end
                end
                if (mul_start_out) begin
                    chk("start_width", prev_start, 0);
                    chk("start_outstanding", n_starts - n_results, 0);
                    chk("start_expected", sb_q.size() != 0, 1);
                    n_starts++;
                    t_start = $time;
                    if (!stale_mode) mul_valid_in = 1'b0;
                    cd = (sb_q.size() != 0) ? sb_q[0].lat : 0;
                end
                prev_start = mul_start_out;
            end
        end
    end

    // Result monitor: pops the scoreboard on each new result and drives res_ready_in.
    initial begin : monitor
        exp_t        e;
        logic [22:0] snap;
        int          held, cur_stall, lat_seen;
        bit          stable_ok;
        res_ready_in = 1'b0;
        held = 0; cur_stall = 0; stable_ok = 1'b1; snap = '0;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                res_ready_in = 1'b0; hold_active = 1'b0; n_results = n_starts;
            end else if (res_valid_out) begin
                if (!hold_active) begin
                    hold_active = 1'b1; held = 0; stable_ok = 1'b1;
                    snap = {res_p_out, res_oor_out, res_tag_out, res_err_out};
                    cur_stall = rand_stall ? int'($urandom_range(0, 3)) : stall_cfg;
                    chk("res_expected", sb_q.size() != 0, 1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        lat_seen = int'(($time - t_start) / 10);
                        chk("res_p", res_p_out, e.p);
                        chk("res_oor", res_oor_out, e.oor);
                        chk("res_tag", res_tag_out, e.tag);
                        chk("res_err", res_err_out, e.err);
                        chk("res_latency", lat_seen, e.exp_cyc);
                    end
                end else if ({res_p_out, res_oor_out, res_tag_out, res_err_out} != snap) begin
                    stable_ok = 1'b0;
                end
                held++;
                if (held > cur_stall) begin
                    if (cur_stall > 0) chk("res_stable", stable_ok, 1);
                    res_ready_in = 1'b1; hold_active = 1'b0; n_results++;
                end else begin
                    res_ready_in = 1'b0;
                end
            end else begin
                res_ready_in = 1'b0;
            end
        end
    end

    initial begin : time_limit
        #400000;
        $display("FAIL time_limit: actual=expired required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        int s0, n;
        int lat_tab[10];
        lat_tab = '{1, 2, 3, 5, 8, 12, 31, 32, 33, 0};
        rst_in = 1'b1; op_valid_in = 1'b0; op_x_in = '0; op_y_in = '0; op_round_in = '0;
        mul_ready_in = 1'b0;
        #2;
        chk("rst_op_ready", op_ready_out, 1);
        chk("rst_mul", {mul_start_out, mul_x_out, mul_y_out, mul_round_out}, 0);
        chk("rst_res", {res_valid_out, res_p_out, res_oor_out, res_tag_out, res_err_out}, 0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;

        // single operation
        mul_ready_in = 1'b1; cur_lat = 12;
        push_op(16'h3FC0, 16'h4000, 2'd0);
        drain("single");

        // backpressure: no issue while the multiplier is not ready
        mul_ready_in = 1'b0; cur_lat = 5; s0 = n_starts;
        for (int i = 0; i < 4; i++) push_op(16'($urandom), 16'($urandom), 2'($urandom));
        chk("full_ready", op_ready_out, 0);
        fork
            begin
                repeat (6) @(negedge clk_in);
                chk("stalled_no_start", n_starts, s0);
                mul_ready_in = 1'b1;
            end
        join_none
        push_op(16'($urandom), 16'($urandom), 2'($urandom));
        drain("backpressure");

        // stale sticky valid held high throughout
        stale_mode = 1'b1; cur_lat = 2;
        for (int i = 0; i < 3; i++) push_op(16'($urandom), 16'($urandom), 2'($urandom));
        drain("stale");
        stale_mode = 1'b0;

        // watchdog, and valid arriving on the timeout cycle / one cycle late
        cur_lat = 0;  push_op(16'h1234, 16'h5678, 2'd1); drain("watchdog");
        cur_lat = 32; push_op(16'h2222, 16'h3333, 2'd2); drain("valid_at_timeout");
        cur_lat = 33; push_op(16'h4444, 16'h5555, 2'd3); drain("valid_after_timeout");
        cur_lat = 1;  push_op(16'h6666, 16'h7777, 2'd0); drain("lat1");

        // result stall with tag wrap
        stall_cfg = 10; cur_lat = 3;
        for (int i = 0; i < 5; i++) push_op(16'($urandom), 16'($urandom), 2'($urandom));
        drain("stall");
        stall_cfg = 0;

        // randomized traffic
        rand_stall = 1'b1; rand_on = 1'b1;
        fork
            begin
                while (rand_on) begin
                    @(negedge clk_in);
                    mul_ready_in = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int i = 0; i < 24; i++) begin
            cur_lat = lat_tab[$urandom_range(0, 9)];
            push_op(16'($urandom), 16'($urandom), 2'($urandom));
            if ($urandom_range(0, 1) == 1) drain("rand_step");
            else repeat ($urandom_range(0, 3)) @(negedge clk_in);
        end
        drain("random");
        rand_on = 1'b0; rand_stall = 1'b0;
        repeat (2) @(negedge clk_in);
        mul_ready_in = 1'b1;

        // asynchronous reset while waiting, two entries still queued
        cur_lat = 12; s0 = n_starts;
        for (int i = 0; i < 3; i++) push_op(16'($urandom), 16'($urandom), 2'($urandom));
        n = 0;
        while (n_starts == s0 && n < 50) begin @(negedge clk_in); n++; end
        repeat (3) @(negedge clk_in);
        #2 rst_in = 1'b1;
        #1;
        chk("arst_op_ready", op_ready_out, 1);
        chk("arst_mul", {mul_start_out, mul_x_out, mul_y_out, mul_round_out}, 0);
        chk("arst_res", {res_valid_out, res_p_out, res_oor_out, res_tag_out, res_err_out}, 0);
        sb_q.delete(); ref_tag = 2'd0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        s0 = n_starts;
        repeat (20) @(negedge clk_in);
        chk("arst_no_start", n_starts, s0);
        chk("arst_ready_after", op_ready_out, 1);
        push_op(16'h3FC0, 16'h4000, 2'd0);
        drain("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
